// File: rtl/uarch_pkg.sv
// Shared micro-architecture definitions for the performance-counter slice.
// Latency: n/a (types, constants and a pure decode helper only).
// Backpressure: n/a.
//
// Contents: CSR address constants, HPM event enumeration and the CSR
// address decoder used by perf_counter_unit for both its read and write ports.
package uarch_pkg;

  // Number of hardware performance-monitor events wired to mhpmcounter3+.
  localparam int NUM_HPM_EVENTS = 4;

  // Machine-mode counter CSRs (lo/hi pairs for RV32 access).
  localparam logic [11:0] CSR_MCYCLE         = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH        = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET       = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH      = 12'hB82;
  localparam logic [11:0] CSR_MHPMCNT_BASE   = 12'hB00;
  localparam logic [11:0] CSR_MHPMCNTH_BASE  = 12'hB80;
  localparam logic [11:0] CSR_MCOUNTINHIBIT  = 12'h320;

  // User-mode read-only shadows.
  localparam logic [11:0] CSR_CYCLE          = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH         = 12'hC80;
  localparam logic [11:0] CSR_INSTRET        = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH       = 12'hC82;
  localparam logic [11:0] CSR_HPMCNT_BASE    = 12'hC00;
  localparam logic [11:0] CSR_HPMCNTH_BASE   = 12'hC80;

  // Upper nibble of the counter pages.
  localparam logic [3:0] CSR_M_PAGE = 4'hB;
  localparam logic [3:0] CSR_U_PAGE = 4'hC;

  typedef enum logic [1:0] {
    EV_BR_MISPRED     = 2'd0,
    EV_FLUSH          = 2'd1,
    EV_DISPATCH_STALL = 2'd2,
    EV_LSQ_FULL       = 2'd3
  } hpm_event_e;

  // Decoded CSR access. idx is the physical counter slot:
  // 0 = mcycle, 1 = minstret, 2+k = mhpmcounter(3+k).
  typedef struct packed {
    logic       hit;   // address is mapped (counter or mcountinhibit)
    logic       inh;   // address is mcountinhibit
    logic       hi;    // upper 32 bits of a counter
    logic [4:0] idx;   // counter slot, valid when hit && !inh
  } csr_dec_t;

  // Maps an address onto a counter slot. Counter number N is taken from
  // addr[4:0]; a nonzero addr[6:5], or N=1 (time), decodes as unmapped.
  function automatic csr_dec_t csr_decode(input logic [11:0] addr,
                                          input int unsigned num_events);
    csr_dec_t   d;
    logic [4:0] n;
    d = '0;
    n = addr[4:0];
    if (addr == CSR_MCOUNTINHIBIT) begin
      d.hit = 1'b1;
      d.inh = 1'b1;
    end else if ((addr[11:8] == CSR_M_PAGE || addr[11:8] == CSR_U_PAGE) &&
                 addr[6:5] == 2'b00) begin
      d.hi = addr[7];
      if (n == 5'd0) begin
        d.hit = 1'b1;
        d.idx = 5'd0;
      end else if (n == 5'd2) begin
        d.hit = 1'b1;
        d.idx = 5'd1;
      end else if (n >= 5'd3 && 32'(n) < num_events + 32'd3) begin
        d.hit = 1'b1;
        d.idx = n - 5'd1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/hpm_counter.sv
// One 64-bit event counter with 32-bit lo/hi write access.
// Latency: increment and writes land on the next clock edge; carry lo->hi is same-cycle.
// Backpressure: none; a write in the same cycle overrides the increment.
//
// Ports: clk/rst (sync, active-high), inc (amount added this cycle), inhibit
// (freeze), wr_lo/wr_hi (replace one half with wr_data), cnt (current value).
module hpm_counter #(
  parameter int CNT_W = 64,
  parameter int INC_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [INC_W-1:0] inc,
  input  logic             inhibit,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic [31:0]      wr_data,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (wr_lo || wr_hi) begin
      // Software write wins: the untouched half keeps its value, no increment.
      cnt <= {(wr_hi ? wr_data : cnt[63:32]), (wr_lo ? wr_data : cnt[31:0])};
    end else if (!inhibit) begin
      cnt <= cnt + CNT_W'(inc);
    end
  end

endmodule

// File: rtl/perf_counter_unit.sv
// mcycle / minstret / mhpmcounter block fed by the commit stage, with a registered CSR port.
// Latency: reads return one cycle after csr_rd_en (pre-edge state); writes take effect next edge.
// Backpressure: none; reads and writes may be issued every cycle.
//
// Ports: clk/rst (sync, active-high); commit_cnt (retired this cycle);
// event_vld (bit k -> mhpmcounter(3+k)); csr_rd_* read port with csr_rd_vld
// response; csr_wr_* write port; csr_illegal pulses alongside the response
// slot of an unmapped access or a write to a user read-only shadow.
module perf_counter_unit
  import uarch_pkg::*;
#(
  parameter int COMMIT_WIDTH = 2,
  parameter int NUM_EVENTS   = NUM_HPM_EVENTS,
  parameter int CNT_W        = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [$clog2(COMMIT_WIDTH+1)-1:0] commit_cnt,
  input  logic [NUM_EVENTS-1:0]             event_vld,
  input  logic                              csr_rd_en,
  input  logic [11:0]                       csr_rd_addr,
  output logic [31:0]                       csr_rd_data,
  output logic                              csr_rd_vld,
  input  logic                              csr_wr_en,
  input  logic [11:0]                       csr_wr_addr,
  input  logic [31:0]                       csr_wr_data,
  output logic                              csr_illegal
);

  localparam int NUM_CNT = 2 + NUM_EVENTS;
  localparam int CC_W    = $clog2(COMMIT_WIDTH + 1);
  localparam int INC_W   = (CC_W > 3) ? CC_W : 3;
  localparam logic [CC_W-1:0] CC_MAX = CC_W'(COMMIT_WIDTH);

  // Implemented mcountinhibit bits: CY (0), IR (2) and one per HPM event.
  localparam logic [31:0] INH_MASK =
    32'h1 | 32'h4 | (((32'h1 << NUM_EVENTS) - 32'h1) << 3);

  logic [31:0]      mcountinhibit;
  logic [CNT_W-1:0] cnt     [NUM_CNT];
  logic [INC_W-1:0] cnt_inc [NUM_CNT];
  logic [NUM_CNT-1:0] cnt_inh;
  logic [NUM_CNT-1:0] cnt_wr_lo;
  logic [NUM_CNT-1:0] cnt_wr_hi;

  csr_dec_t    rd_dec;
  csr_dec_t    wr_dec;
  logic        wr_user;
  logic        wr_cnt;
  logic        wr_inh;
  logic        rd_ill;
  logic        wr_ill;
  logic [31:0] rd_val;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_dec  = csr_decode(csr_rd_addr, NUM_EVENTS);
    wr_dec  = csr_decode(csr_wr_addr, NUM_EVENTS);
    wr_user = (csr_wr_addr[11:8] == CSR_U_PAGE);

    rd_ill  = csr_rd_en && !rd_dec.hit;
    // User shadows are read-only; writing them is rejected without side effects.
    wr_ill  = csr_wr_en && (!wr_dec.hit || wr_user);

    wr_cnt  = csr_wr_en && wr_dec.hit && !wr_dec.inh && !wr_user;
    wr_inh  = csr_wr_en && wr_dec.inh;
  end

  // ---------------------------------------------------------------------------
  // Counter slots
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    if (i == 0) begin : g_cycle
      assign cnt_inc[i] = INC_W'(1);
      assign cnt_inh[i] = mcountinhibit[0];
    end else if (i == 1) begin : g_instret
      assign cnt_inc[i] = INC_W'(commit_cnt);
      assign cnt_inh[i] = mcountinhibit[2];
    end else begin : g_event
      assign cnt_inc[i] = INC_W'(event_vld[i-2]);
      assign cnt_inh[i] = mcountinhibit[i+1];
    end

    assign cnt_wr_lo[i] = wr_cnt && !wr_dec.hi && (wr_dec.idx == 5'(i));
    assign cnt_wr_hi[i] = wr_cnt &&  wr_dec.hi && (wr_dec.idx == 5'(i));

    hpm_counter #(
      .CNT_W (CNT_W),
      .INC_W (INC_W)
    ) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc     (cnt_inc[i]),
      .inhibit (cnt_inh[i]),
      .wr_lo   (cnt_wr_lo[i]),
      .wr_hi   (cnt_wr_hi[i]),
      .wr_data (csr_wr_data),
      .cnt     (cnt[i])
    );
  end

  // ---------------------------------------------------------------------------
  // Read mux (pre-edge values, so a same-cycle write is not visible)
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_val = '0;
    if (rd_dec.inh) begin
      rd_val = mcountinhibit;
    end else if (rd_dec.hit) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (rd_dec.idx == 5'(i)) begin
          rd_val = rd_dec.hi ? cnt[i][63:32] : cnt[i][31:0];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // mcountinhibit and registered CSR response
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      mcountinhibit <= '0;
      csr_rd_data   <= '0;
      csr_rd_vld    <= 1'b0;
      csr_illegal   <= 1'b0;
    end else begin
      // The counters see the old value during the write cycle.
      if (wr_inh) begin
        mcountinhibit <= csr_wr_data & INH_MASK;
      end
      csr_rd_vld  <= csr_rd_en;
      csr_rd_data <= csr_rd_en ? rd_val : 32'd0;
      // One pulse even if both the read and the write are illegal.
      csr_illegal <= rd_ill || wr_ill;
    end
  end

  // Retiring more than COMMIT_WIDTH per cycle is an upstream bug; the value
  // is still accumulated so the counter tracks what was actually reported.
  a_commit_cnt_range: assert property (
    @(posedge clk) disable iff (rst) commit_cnt <= CC_MAX
  );

endmodule

// File: doc/perf_counter_unit.md
Name: perf_counter_unit

Overview:
Machine/user performance-counter block that sits directly downstream of the commit stage. It consumes the per-cycle retire count `commit_cnt` plus single-bit microarchitectural event strobes. It maintains 64-bit mcycle, minstret and NUM_EVENTS mhpmcounters, and serves them over a registered CSR read/write port. In hardware it replaces the cycle/instruction/IPC bookkeeping the CPU bench currently does itself.

Parameters:
COMMIT_WIDTH, 2, max instructions retired per cycle; sets `commit_cnt` width.
NUM_EVENTS, 4, number of mhpmcounterN (N = 3..3+NUM_EVENTS-1); legal range 1..29.
CNT_W, 64, counter width; fixed at 64 for RV32 lo/hi access.

Ports:
clk  in  1  core clock, single domain
rst  in  1  synchronous, active-high reset
commit_cnt  in  $clog2(COMMIT_WIDTH+1)  instructions retired this cycle
event_vld  in  NUM_EVENTS  per-cycle event strobes (bit k feeds mhpmcounter(3+k))
csr_rd_en  in  1  read request
csr_rd_addr  in  12  read CSR address
csr_rd_data  out  32  read data, valid with `csr_rd_vld`
csr_rd_vld  out  1  read response, one cycle after `csr_rd_en`
csr_wr_en  in  1  write request
csr_wr_addr  in  12  write CSR address
csr_wr_data  in  32  write data
csr_illegal  out  1  pulse: previous-cycle access was unmapped or read-only

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - All counters = 0; mcountinhibit = 0.
  - `csr_rd_data` = 0; `csr_rd_vld` = 0; `csr_illegal` = 0.
  - Events and commits in the reset cycle are not counted.
- Increments, each cycle unless inhibited:
  - mcycle += 1.
  - minstret += `commit_cnt`, zero-extended to 64b.
  - mhpmcounter(3+k) += `event_vld[k]`.
- Arithmetic: modulo 2^64. 0xFFFFFFFF_FFFFFFFF + 1 -> 0. Carry from lo into hi happens in the same cycle, with no extra latency.
- mcountinhibit (0x320, RW):
  - bit0 gates mcycle; bit2 gates minstret; bit(3+k) gates mhpmcounter(3+k).
  - bit1 and unimplemented bits read 0 and ignore writes.
  - An inhibit write takes effect from the next cycle. The write cycle itself still counts under the old inhibit value.
- Address map:
  - Machine RW: mcycle 0xB00/0xB80 (lo/hi), minstret 0xB02/0xB82, mhpmcounterN 0xB00+N / 0xB80+N.
  - User read-only shadows: cycle 0xC00/0xC80, instret 0xC02/0xC82, hpmcounterN 0xC00+N / 0xC80+N.
- Writes:
  - Writing lo replaces bits[31:0] and keeps hi; writing hi replaces bits[63:32] and keeps lo.
  - For the written counter, the write wins over the increment in that cycle: value after the edge = written value exactly, with no +1.
  - Other counters increment normally.
- Reads:
  - 1-cycle latency: `csr_rd_vld` and `csr_rd_data` are registered from the pre-edge state of the `csr_rd_en` cycle.
  - A read-during-write to the same CSR returns the old value.
  - `csr_rd_en` may be asserted back-to-back every cycle. There is no backpressure.
- Illegal access:
  - Applies to an unmapped address, or a write to any 0xCxx address.
  - `csr_illegal` = 1 for one cycle, aligned with where `csr_rd_vld` would be; no state change.
  - For an illegal read, `csr_rd_vld` = 1 and `csr_rd_data` = 0.
  - If both read and write are illegal in the same cycle, a single pulse is raised.
- Simultaneous read and write to different CSRs are both serviced.
- `commit_cnt` > COMMIT_WIDTH is a protocol violation; the simulation assertion fires and the value is still added.

Decomposition:
- uarch_pkg gains:
  - CSR address constants (CSR_MCYCLE, CSR_MINSTRET, CSR_MHPMCNT_BASE, CSR_MCOUNTINHIBIT, user shadows).
  - NUM_HPM_EVENTS.
  - Enum hpm_event_e: EV_BR_MISPRED=0, EV_FLUSH=1, EV_DISPATCH_STALL=2, EV_LSQ_FULL=3.
- One sub-module, hpm_counter, instantiated 2+NUM_EVENTS times. It holds one 64-bit register with:
  - inc amount (3b)
  - inhibit
  - wr_lo / wr_hi strobes
  - wr_data

Test Plan:
- Count and read: release rst, run 100 cycles with `commit_cnt` alternating 2,0, then read 0xB00 and 0xB02 -> mcycle lo = 100 (+1 per read-issue cycle, checked exactly), minstret lo = 100; `csr_rd_vld` one cycle after each `csr_rd_en`.
- Carry: write 0xB00 = 0xFFFFFFFF and 0xB80 = 0; one cycle later read 0xB80 -> 0x00000001, and 0xB00 -> a small value (exact cycle count); also preload 0xFFFFFFFF_FFFFFFFF -> wraps to 0.
- Write wins: write minstret lo = 0x10 in a cycle with `commit_cnt` = 2 -> reads 0x10 next cycle, then 0x12 after one more `commit_cnt` = 2 cycle.
- Inhibit: write 0x320 = 0x5, hold `commit_cnt` = 2 for 20 cycles -> mcycle and minstret frozen, hpm3 still counts `event_vld[0]` pulses (10 pulses -> 10); clear 0x320 -> counting resumes next cycle.
- Illegal: write 0xC00 = 5 -> `csr_illegal` pulse, cycle unchanged; read 0x7FF -> `csr_rd_vld` = 1, data = 0, `csr_illegal` = 1; read 0xC03 -> equals 0xB03.
- Reset mid-operation: assert rst for 1 cycle while a read is in flight -> `csr_rd_vld` = 0 next cycle, all counters read 0, mcountinhibit = 0.
